// File: rtl/tdm_pkg.sv
// ---------------------------------------------------------------------------
// tdm_pkg
// Shared constants and types for the four-slot TDM receive path.
//   SLOTS     : slots per frame (one serial bit each)
//   SLOT_W    : width of the slot index
//   LAST_SLOT : index of the slot that completes a frame
//   state_t   : framing state (HUNT = searching for sync, LOCKED = aligned)
// ---------------------------------------------------------------------------
package tdm_pkg;

    localparam int SLOTS  = 4;
    localparam int SLOT_W = 2;

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_demux4_rx_if.sv
// ---------------------------------------------------------------------------
// tdm_demux4_rx_if
// Bundles the serial link side and the parallel consumer side of the TDM
// demultiplexer.
//   din_valid, din, sync : serial beat from the link (driven by master)
//   q, q_valid           : completed 4-bit frame and its one-cycle strobe
//   slot                 : index of the next expected slot
//   locked, sync_err     : framing status and framing-violation pulse
// Modports:
//   master : link/consumer side (drives the beat, observes results)
//   slave  : the demultiplexer itself
// ---------------------------------------------------------------------------
interface tdm_demux4_rx_if;
    import tdm_pkg::*;

    logic              din_valid;
    logic              din;
    logic              sync;
    logic [SLOTS-1:0]  q;
    logic              q_valid;
    logic [SLOT_W-1:0] slot;
    logic              locked;
    logic              sync_err;

    modport master (
        output din_valid, din, sync,
        input  q, q_valid, slot, locked, sync_err
    );

    modport slave (
        input  din_valid, din, sync,
        output q, q_valid, slot, locked, sync_err
    );

endinterface

// File: rtl/tdm_slot_counter.sv
// ---------------------------------------------------------------------------
// tdm_slot_counter
// Slot index tracker for the TDM receiver: a wrapping counter that can be
// cleared (lock dropped), loaded to 1 (slot 0 just consumed on a sync beat)
// or advanced by one (ordinary accepted beat).
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : force the index back to 0
//   load       : force the index to 1
//   en         : advance the index, wrapping after the last slot
//   count      : current index of the next expected slot
// ---------------------------------------------------------------------------
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic              en,
    output logic [SLOT_W-1:0] count
);

    // Clear outranks load so a dropped lock always wins; the counter wraps
    // naturally because its width matches the slot count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= SLOT_W'(1);
        end else if (en) begin
            count <= count + SLOT_W'(1);
        end
    end

endmodule

// File: rtl/tdm_demux4_rx.sv
// ---------------------------------------------------------------------------
// tdm_demux4_rx
// Four-slot time-division demultiplexer. Locks onto a frame sync, tracks the
// slot index, collects slot bits into a shadow register and publishes a full
// 4-bit frame with a one-cycle valid pulse when the last slot arrives.
//   REQUIRE_SYNC : 1 = sync must mark every slot-0 beat, 0 = free-running
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus          : slave side of tdm_demux4_rx_if (beat in, frame/status out)
// ---------------------------------------------------------------------------
module tdm_demux4_rx
    import tdm_pkg::*;
#(
    parameter bit REQUIRE_SYNC = 1'b1
)
(
    input  logic            clk,
    input  logic            rst_n,
    tdm_demux4_rx_if.slave  bus
);

    state_t            state_q;
    state_t            state_d;
    logic [SLOT_W-1:0] slot_q;

    logic              cnt_clr;
    logic              cnt_load;
    logic              cnt_en;
    logic              shadow_we;
    logic [SLOT_W-1:0] shadow_idx;
    logic              frame_done;
    logic              err_d;

    // Slots 0..2 wait here; slot 3 goes straight into q with them.
    logic [SLOTS-2:0]  shadow_q;
    logic [SLOTS-1:0]  q_q;
    logic              q_valid_q;
    logic              sync_err_q;

    tdm_slot_counter u_slot_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .load  (cnt_load),
        .en    (cnt_en),
        .count (slot_q)
    );

    // Framing state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Beat decoding. A sync beat out of place realigns without leaving
    // LOCKED; a missing sync on slot 0 only drops lock when REQUIRE_SYNC is
    // set, otherwise the beat is simply taken as slot 0.
    always_comb begin
        state_d    = state_q;
        cnt_clr    = 1'b0;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;
        shadow_we  = 1'b0;
        shadow_idx = slot_q;
        frame_done = 1'b0;
        err_d      = 1'b0;

        if (bus.din_valid) begin
            case (state_q)
                HUNT: begin
                    if (bus.sync) begin
                        state_d    = LOCKED;
                        cnt_load   = 1'b1;
                        shadow_we  = 1'b1;
                        shadow_idx = '0;
                    end
                end
                LOCKED: begin
                    if (bus.sync && (slot_q != '0)) begin
                        err_d      = 1'b1;
                        cnt_load   = 1'b1;
                        shadow_we  = 1'b1;
                        shadow_idx = '0;
                    end else if (!bus.sync && (slot_q == '0) && REQUIRE_SYNC) begin
                        err_d      = 1'b1;
                        state_d    = HUNT;
                        cnt_clr    = 1'b1;
                    end else if (slot_q == LAST_SLOT) begin
                        frame_done = 1'b1;
                        cnt_en     = 1'b1;
                    end else begin
                        shadow_we  = 1'b1;
                        cnt_en     = 1'b1;
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    // Shadow and output registers. q is written in one shot from the shadow
    // plus the live slot-3 bit, so consumers never see a partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q   <= '0;
            q_q        <= '0;
            q_valid_q  <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            if (shadow_we) begin
                shadow_q[shadow_idx] <= bus.din;
            end
            if (frame_done) begin
                q_q <= {bus.din, shadow_q};
            end
            q_valid_q  <= frame_done;
            sync_err_q <= err_d;
        end
    end

    assign bus.q        = q_q;
    assign bus.q_valid  = q_valid_q;
    assign bus.slot     = slot_q;
    assign bus.locked   = (state_q == LOCKED);
    assign bus.sync_err = sync_err_q;

endmodule

// File: tb/tb_tdm_demux4_rx.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux4_rx
// Drives one serial stream into two receivers (REQUIRE_SYNC = 1 and 0) and
// compares every cycle against a behavioural framing model. Completed frames
// are queued by the model and popped by a monitor whenever q_valid is seen.
// ---------------------------------------------------------------------------
module tb_tdm_demux4_rx;
    import tdm_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic drv_valid;
    logic drv_din;
    logic drv_sync;

    tdm_demux4_rx_if bus_req ();
    tdm_demux4_rx_if bus_free ();

    assign bus_req.din_valid  = drv_valid;
    assign bus_req.din        = drv_din;
    assign bus_req.sync       = drv_sync;
    assign bus_free.din_valid = drv_valid;
    assign bus_free.din       = drv_din;
    assign bus_free.sync      = drv_sync;

    tdm_demux4_rx #(.REQUIRE_SYNC(1'b1)) u_req (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_req)
    );

    tdm_demux4_rx #(.REQUIRE_SYNC(1'b0)) u_free (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_free)
    );

    always #5 clk = ~clk;

    // Reference model state, index 0 = REQUIRE_SYNC receiver, 1 = free-running.
    bit         m_locked [2];
    int         m_next   [2];
    int         m_bits   [2][4];
    bit         m_qv     [2];
    bit         m_err    [2];
    logic [3:0] m_held   [2];
    logic [3:0] exp_q0   [$];
    logic [3:0] exp_q1   [$];

    int n_checks = 0;
    int n_errors = 0;

    function automatic void model_reset();
        for (int u = 0; u < 2; u++) begin
            m_locked[u] = 1'b0;
            m_next[u]   = 0;
            m_qv[u]     = 1'b0;
            m_err[u]    = 1'b0;
            m_held[u]   = 4'b0000;
            for (int k = 0; k < 4; k++) m_bits[u][k] = 0;
        end
        exp_q0.delete();
        exp_q1.delete();
    endfunction

    // Framing rules applied to one clock edge for one receiver.
    function automatic void model_edge(int u, bit req, bit v, bit d, bit s);
        int word;
        m_qv[u]  = 1'b0;
        m_err[u] = 1'b0;
        if (!v) return;
        if (!m_locked[u]) begin
            if (s) begin
                m_locked[u]  = 1'b1;
                m_bits[u][0] = int'(d);
                m_next[u]    = 1;
            end
        end else if (s && m_next[u] != 0) begin
            m_err[u]     = 1'b1;
            m_bits[u][0] = int'(d);
            m_next[u]    = 1;
        end else if (!s && m_next[u] == 0 && req) begin
            m_err[u]    = 1'b1;
            m_locked[u] = 1'b0;
            m_next[u]   = 0;
        end else begin
            m_bits[u][m_next[u]] = int'(d);
            if (m_next[u] == 3) begin
                word = 0;
                for (int k = 0; k < 4; k++) word += m_bits[u][k] * (1 << k);
                if (u == 0) exp_q0.push_back(4'(word));
                else        exp_q1.push_back(4'(word));
                m_qv[u]   = 1'b1;
                m_next[u] = 0;
            end else begin
                m_next[u] = m_next[u] + 1;
            end
        end
    endfunction

    task automatic compare(input string name, input int u,
                           input logic [3:0] got, input logic [3:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("[TB] FAIL u%0d %s: got %b expected %b at %0t", u, name, got, want, $time);
        end
    endtask

    task automatic checkOutput(input int u, input logic [3:0] q, input logic qv,
                               input logic [1:0] sl, input logic lk, input logic se);
        compare("q_valid", u, {3'b000, qv}, {3'b000, m_qv[u]});
        if (qv === 1'b1) begin
            if (u == 0 && exp_q0.size() > 0) begin
                m_held[u] = exp_q0.pop_front();
            end else if (u == 1 && exp_q1.size() > 0) begin
                m_held[u] = exp_q1.pop_front();
            end else begin
                n_checks++;
                n_errors++;
                $display("[TB] FAIL u%0d unexpected_frame: got q=%b expected no frame", u, q);
            end
        end
        compare("q",        u, q,              m_held[u]);
        compare("slot",     u, {2'b00, sl},    4'(m_next[u]));
        compare("locked",   u, {3'b000, lk},   {3'b000, m_locked[u]});
        compare("sync_err", u, {3'b000, se},   {3'b000, m_err[u]});
    endtask

    // Monitor: outputs are sampled half a cycle after the active edge.
    always @(negedge clk) begin
        checkOutput(0, bus_req.q,  bus_req.q_valid,  bus_req.slot,  bus_req.locked,  bus_req.sync_err);
        checkOutput(1, bus_free.q, bus_free.q_valid, bus_free.slot, bus_free.locked, bus_free.sync_err);
    end

    // One clock of stimulus; caller is positioned at a falling edge.
    task automatic applyStimulus(input bit v, input bit d, input bit s);
        drv_valid = v;
        drv_din   = d;
        drv_sync  = s;
        @(posedge clk);
        model_edge(0, 1'b1, v, d, s);
        model_edge(1, 1'b0, v, d, s);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset in the middle of a cycle, checked before any edge.
    task automatic resetMid();
        drv_valid = 1'b0;
        drv_sync  = 1'b0;
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        checkOutput(0, bus_req.q,  bus_req.q_valid,  bus_req.slot,  bus_req.locked,  bus_req.sync_err);
        checkOutput(1, bus_free.q, bus_free.q_valid, bus_free.slot, bus_free.locked, bus_free.sync_err);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit v, d, s;
        int tx_pos;
        drv_valid = 1'b0;
        drv_din   = 1'b0;
        drv_sync  = 1'b0;
        rst_n     = 1'b1;
        model_reset();
        #3 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] basic frame");
        applyStimulus(1, 1, 1);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 1, 0);
        applyStimulus(1, 1, 0);
        compare("basic_q", 0, bus_req.q, 4'b1101);
        idle(2);

        $display("[TB] gapped beats");
        applyStimulus(1, 1, 1); idle(3);
        applyStimulus(1, 0, 0); idle(3);
        applyStimulus(1, 1, 0); idle(3);
        applyStimulus(1, 1, 0);
        compare("gapped_q", 1, bus_free.q, 4'b1101);
        idle(2);

        $display("[TB] early sync");
        applyStimulus(1, 1, 1);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 1);
        applyStimulus(1, 1, 0);
        applyStimulus(1, 1, 0);
        applyStimulus(1, 1, 0);
        compare("early_sync_q", 0, bus_req.q, 4'b1110);
        idle(2);

        $display("[TB] missing sync");
        applyStimulus(1, 0, 1);
        applyStimulus(1, 1, 0);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 1, 0);
        applyStimulus(1, 1, 0);
        for (int i = 0; i < 7; i++) applyStimulus(1, i[0], 0);
        compare("missing_sync_locked_req",  0, {3'b000, bus_req.locked},  4'b0000);
        compare("missing_sync_locked_free", 1, {3'b000, bus_free.locked}, 4'b0001);
        applyStimulus(1, 1, 1);
        applyStimulus(1, 1, 0);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0);
        idle(2);

        $display("[TB] reset mid-frame");
        applyStimulus(1, 1, 1);
        applyStimulus(1, 1, 0);
        applyStimulus(1, 1, 0);
        resetMid();
        applyStimulus(1, 0, 1);
        applyStimulus(1, 1, 0);
        applyStimulus(1, 1, 0);
        applyStimulus(1, 0, 0);
        compare("reset_q", 0, bus_req.q, 4'b0110);
        idle(2);

        $display("[TB] random stream");
        tx_pos = 0;
        for (int i = 0; i < 800; i++) begin
            if (i == 400) begin
                resetMid();
                tx_pos = 0;
            end
            v = ($urandom_range(0, 3) != 0);
            d = 1'($urandom_range(0, 1));
            if (v) begin
                s = (tx_pos == 0);
                if ($urandom_range(0, 19) == 0) s = !s;
                tx_pos = (tx_pos + 1) % 4;
                if ($urandom_range(0, 29) == 0) tx_pos = (tx_pos + 1) % 4;
            end else begin
                s = 1'($urandom_range(0, 1));
            end
            applyStimulus(v, d, s);
        end
        idle(3);

        compare("pending_frames", 0, 4'(exp_q0.size()), 4'd0);
        compare("pending_frames", 1, 4'(exp_q1.size()), 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
